// File: rtl/mtimer_if.sv
// mtimer_if: CPU data-bus request/response bundle between the CPU master and the mtimer slave.
interface mtimer_if;
    logic [31:0] i_bus_address;
    logic [31:0] i_bus_data;
    logic        i_bus_DV;
    logic [2:0]  i_bhw;
    logic        i_write_notread;
    logic [31:0] o_bus_data;
    logic        o_bus_DV;

    modport master (
        output i_bus_address, i_bus_data, i_bus_DV, i_bhw, i_write_notread,
        input  o_bus_data, o_bus_DV
    );
    modport slave (
        input  i_bus_address, i_bus_data, i_bus_DV, i_bhw, i_write_notread,
        output o_bus_data, o_bus_DV
    );
endinterface

// File: rtl/mtimer.sv
// mtimer: memory-mapped 64-bit mtime/mtimecmp machine timer with level interrupt.
// Define MTIMER_SNAPSHOT_EN to latch mtime[63:32] on MTIME_LO reads for tear-free LO/HI pairs.
module mtimer #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    mtimer_if.slave bus,
    output logic    o_timer_int
);
    localparam logic [15:0] PCNT_MAX = 16'(PRESCALE - 1);

    logic [63:0] r_mtime, r_mtimecmp, w_mtime_inc, w_mtime_nx, w_cmp_nx;
    logic [31:0] r_rdata, w_rdata, w_hi_rd;
    logic [15:0] r_pcnt, w_off;
    logic        r_dv, r_int;
    logic        w_sel, w_rd, w_wr, w_tick, w_wr_tlo, w_wr_thi, w_wr_clo, w_wr_chi;

    function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] d,
                                            input logic [2:0] bhw, input logic [1:0] a);
        logic [31:0] r;
        r = old;
        if (bhw == 3'b001) r[{a, 3'b000} +: 8] = d[7:0];
        else if (bhw == 3'b010) r[{a[1], 4'b0000} +: 16] = d[15:0];
        else r = d;
        return r;
    endfunction

    assign w_sel    = bus.i_bus_DV && (bus.i_bus_address[31:16] == BASE_ADDR[31:16]);
    assign w_off    = {bus.i_bus_address[15:2], 2'b00};
    assign w_wr     = w_sel && bus.i_write_notread;
    assign w_rd     = w_sel && !bus.i_write_notread;
    assign w_wr_clo = w_wr && (w_off == 16'h4000);
    assign w_wr_chi = w_wr && (w_off == 16'h4004);
    assign w_wr_tlo = w_wr && (w_off == 16'hBFF8);
    assign w_wr_thi = w_wr && (w_off == 16'hBFFC);
    assign w_tick   = (r_pcnt == PCNT_MAX);

    // A write to either mtime half swallows that cycle's tick for the whole register.
    assign w_mtime_inc = w_tick ? r_mtime + 64'd1 : r_mtime;
    assign w_mtime_nx  = (w_wr_tlo || w_wr_thi) ?
        {w_wr_thi ? f_merge(r_mtime[63:32], bus.i_bus_data, bus.i_bhw, bus.i_bus_address[1:0]) : r_mtime[63:32],
         w_wr_tlo ? f_merge(r_mtime[31:0], bus.i_bus_data, bus.i_bhw, bus.i_bus_address[1:0]) : r_mtime[31:0]} :
        w_mtime_inc;
    assign w_cmp_nx =
        {w_wr_chi ? f_merge(r_mtimecmp[63:32], bus.i_bus_data, bus.i_bhw, bus.i_bus_address[1:0]) : r_mtimecmp[63:32],
         w_wr_clo ? f_merge(r_mtimecmp[31:0], bus.i_bus_data, bus.i_bhw, bus.i_bus_address[1:0]) : r_mtimecmp[31:0]};

`ifdef MTIMER_SNAPSHOT_EN
    logic [31:0] r_snap;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_snap <= '0;
        else if (w_rd && (w_off == 16'hBFF8)) r_snap <= r_mtime[63:32];
    end
    assign w_hi_rd = r_snap;
`else
    assign w_hi_rd = r_mtime[63:32];
`endif

    assign w_rdata = (w_off == 16'h4000) ? r_mtimecmp[31:0]  :
                     (w_off == 16'h4004) ? r_mtimecmp[63:32] :
                     (w_off == 16'hBFF8) ? r_mtime[31:0]     :
                     (w_off == 16'hBFFC) ? w_hi_rd           : 32'd0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pcnt     <= '0;
            r_mtime    <= '0;
            r_mtimecmp <= '1;
            r_dv       <= 1'b0;
            r_rdata    <= '0;
            r_int      <= 1'b0;
        end else begin
            r_pcnt     <= w_tick ? 16'd0 : r_pcnt + 16'd1;
            r_mtime    <= w_mtime_nx;
            r_mtimecmp <= w_cmp_nx;
            r_dv       <= w_sel;
            if (w_rd) r_rdata <= w_rdata;
            r_int      <= (w_mtime_nx >= w_cmp_nx);
        end
    end

    assign bus.o_bus_data = r_rdata;
    assign bus.o_bus_DV   = r_dv;
    assign o_timer_int    = r_int;
endmodule

// File: tb/tb_mtimer.sv
// tb_mtimer: checks two mtimer instances (PRESCALE 1 and 4) fed the same bus traffic against a cycle model.
module tb_mtimer;
    localparam logic [31:0] A_CLO = 32'h0200_4000;
    localparam logic [31:0] A_CHI = 32'h0200_4004;
    localparam logic [31:0] A_TLO = 32'h0200_BFF8;
    localparam logic [31:0] A_THI = 32'h0200_BFFC;
`ifdef MTIMER_SNAPSHOT_EN
    localparam bit SNAP = 1'b1;
`else
    localparam bit SNAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic int1, int4;
    int   n_cmp = 0;
    int   n_bad = 0;

    mtimer_if b1 ();
    mtimer_if b4 ();
    assign b4.i_bus_address   = b1.i_bus_address;
    assign b4.i_bus_data      = b1.i_bus_data;
    assign b4.i_bus_DV        = b1.i_bus_DV;
    assign b4.i_bhw           = b1.i_bhw;
    assign b4.i_write_notread = b1.i_write_notread;

    mtimer #(.PRESCALE(1)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(b1.slave), .o_timer_int(int1));
    mtimer #(.PRESCALE(4)) dut4 (.i_clk(clk), .i_rst_n(rst_n), .bus(b4.slave), .o_timer_int(int4));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    logic [63:0] m_mt [2];
    logic [63:0] m_cmp [2];
    logic [31:0] m_snap [2];
    logic [31:0] e_data [2];
    int          m_pc [2];
    logic        e_dv [2];
    logic        e_int [2];
    logic        e_rd [2];

    function automatic logic [31:0] f_wr(logic [31:0] old, logic [31:0] d, logic [1:0] a, logic [2:0] bhw);
        int n, lane;
        logic [31:0] r;
        r = old;
        n = (bhw == 3'b001) ? 1 : (bhw == 3'b010) ? 2 : 4;
        lane = (n == 1) ? int'(a) : (n == 2) ? (a[1] ? 2 : 0) : 0;
        for (int i = 0; i < n; i++) r[8*(lane+i) +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mt[k] = '0; m_cmp[k] = '1; m_snap[k] = '0; m_pc[k] = 0;
            e_dv[k] = 1'b0; e_int[k] = 1'b0; e_rd[k] = 1'b0; e_data[k] = '0;
        end
    endtask

    task automatic model_k(int k);
        logic sel, rd, wr, tick;
        logic [15:0] off;
        logic [31:0] a, d, rv;
        logic [63:0] mt, cmp;
        a = b1.i_bus_address;
        d = b1.i_bus_data;
        sel = b1.i_bus_DV && (a[31:16] == 16'h0200);
        off = {a[15:2], 2'b00};
        wr = sel && b1.i_write_notread;
        rd = sel && !b1.i_write_notread;
        mt = m_mt[k];
        cmp = m_cmp[k];
        case (off)
            16'h4000: rv = cmp[31:0];
            16'h4004: rv = cmp[63:32];
            16'hBFF8: rv = mt[31:0];
            16'hBFFC: rv = SNAP ? m_snap[k] : mt[63:32];
            default:  rv = 32'd0;
        endcase
        if (rd && off == 16'hBFF8) m_snap[k] = mt[63:32];
        e_dv[k] = sel;
        e_rd[k] = rd;
        if (rd) e_data[k] = rv;
        tick = (m_pc[k] == (k ? 4 : 1) - 1);
        m_pc[k] = tick ? 0 : m_pc[k] + 1;
        if (wr && off == 16'hBFF8) mt[31:0] = f_wr(mt[31:0], d, a[1:0], b1.i_bhw);
        else if (wr && off == 16'hBFFC) mt[63:32] = f_wr(mt[63:32], d, a[1:0], b1.i_bhw);
        else if (tick) mt = mt + 64'd1;
        if (wr && off == 16'h4000) cmp[31:0] = f_wr(cmp[31:0], d, a[1:0], b1.i_bhw);
        if (wr && off == 16'h4004) cmp[63:32] = f_wr(cmp[63:32], d, a[1:0], b1.i_bhw);
        m_mt[k] = mt;
        m_cmp[k] = cmp;
        e_int[k] = (mt >= cmp);
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("dv_p1", b1.o_bus_DV, e_dv[0]);
        chk("dv_p4", b4.o_bus_DV, e_dv[1]);
        chk("int_p1", int1, e_int[0]);
        chk("int_p4", int4, e_int[1]);
        if (e_rd[0]) chk("rdata_p1", b1.o_bus_data, e_data[0]);
        if (e_rd[1]) chk("rdata_p4", b4.o_bus_data, e_data[1]);
        if (!rst_n) chk("rst_rdata", b1.o_bus_data, 0);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) begin
            model_k(0);
            model_k(1);
        end
        #1;
        check_all();
    endtask

    task automatic drive(bit dv, bit wr, logic [31:0] a, logic [31:0] d, logic [2:0] bhw);
        b1.i_bus_DV = dv;
        b1.i_write_notread = wr;
        b1.i_bus_address = a;
        b1.i_bus_data = d;
        b1.i_bhw = bhw;
    endtask

    task automatic req(bit dv, bit wr, logic [31:0] a, logic [31:0] d, logic [2:0] bhw);
        drive(dv, wr, a, d, bhw);
        step();
    endtask

    task automatic idle(int n);
        repeat (n) req(1'b0, 1'b0, 32'd0, 32'd0, 3'b100);
    endtask

    task automatic do_reset(int n);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (n) step();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 3'b100);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] v0, v1;
        int cnt;
        bit found;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 3'b100);
        do_reset(3);

        idle(10);
        req(1'b1, 1'b0, A_TLO, 32'd0, 3'b100);
        v0 = b1.o_bus_data;
        chk("lo_after_10", 64'(v0 >= 9 && v0 <= 11), 1);
        chk("lo_resp_dv", b1.o_bus_DV, 1);

        req(1'b1, 1'b1, A_CHI, 32'd0, 3'b100);
        req(1'b1, 1'b1, A_CLO, 32'd20, 3'b100);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            idle(1);
            found = int1;
        end
        chk("int_rise_seen", found, 1);
        req(1'b1, 1'b0, A_TLO, 32'd0, 3'b100);
        chk("int_rise_mtime", b1.o_bus_data, 20);
        req(1'b1, 1'b1, A_CHI, 32'd1, 3'b100);
        chk("int_fall", int1, 0);

        req(1'b1, 1'b1, A_CLO, 32'hFFFF_FFFF, 3'b100);
        req(1'b1, 1'b1, 32'h0200_4002, 32'h0000_00AB, 3'b001);
        req(1'b1, 1'b0, A_CLO, 32'd0, 3'b100);
        chk("byte_wr", b1.o_bus_data, 32'hFFAB_FFFF);
        req(1'b1, 1'b1, 32'h0200_4003, 32'h0000_1234, 3'b010);
        req(1'b1, 1'b0, A_CLO, 32'd0, 3'b100);
        chk("half_wr", b1.o_bus_data, 32'h1234_FFFF);

        req(1'b1, 1'b1, A_THI, 32'd0, 3'b100);
        req(1'b1, 1'b1, A_TLO, 32'hFFFF_FFFE, 3'b100);
        idle(1);
        req(1'b1, 1'b0, A_TLO, 32'd0, 3'b100);
        chk("pre_carry_lo", b1.o_bus_data, 32'hFFFF_FFFF);
        req(1'b1, 1'b0, A_THI, 32'd0, 3'b100);
        chk("pair_hi", b1.o_bus_data, SNAP ? 0 : 1);
        req(1'b1, 1'b1, A_THI, 32'hFFFF_FFFF, 3'b100);
        req(1'b1, 1'b1, A_TLO, 32'hFFFF_FFFF, 3'b100);
        chk("all_ones_int", int1, 1);
        idle(1);
        req(1'b1, 1'b0, A_TLO, 32'd0, 3'b100);
        chk("wrap_lo", b1.o_bus_data, 0);
        req(1'b1, 1'b0, A_THI, 32'd0, 3'b100);
        chk("wrap_hi", b1.o_bus_data, 0);

        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            req(1'b1, 1'b0, A_TLO, 32'd0, 3'b100);
            cnt += int'(b4.o_bus_DV);
        end
        chk("b2b_pulses", cnt, 4);
        req(1'b1, 1'b0, A_TLO, 32'd0, 3'b100);
        v0 = b4.o_bus_data;
        idle(7);
        req(1'b1, 1'b0, A_TLO, 32'd0, 3'b100);
        v1 = b4.o_bus_data;
        chk("prescale4_delta", v1 - v0, 2);
        req(1'b1, 1'b0, 32'h0300_0000, 32'd0, 3'b100);
        chk("nosel_dv", b1.o_bus_DV, 0);
        req(1'b1, 1'b0, 32'h0200_0010, 32'd0, 3'b100);
        chk("hole_dv", b1.o_bus_DV, 1);
        chk("hole_data", b1.o_bus_data, 0);

        drive(1'b1, 1'b0, A_TLO, 32'd0, 3'b100);
        do_reset(2);
        idle(2);
        chk("post_rst_dv", b1.o_bus_DV, 0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, d;
            case ($urandom_range(0, 7))
                0: a = A_CLO;
                1: a = A_CHI;
                2, 6: a = A_TLO;
                3: a = A_THI;
                4: a = 32'h0200_0000 | $urandom_range(0, 16'hFFFF);
                5: a = 32'h0300_0000 | $urandom_range(0, 16'hFFFF);
                default: a = A_CLO;
            endcase
            a[1:0] = 2'($urandom_range(0, 3));
            d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 300));
            req($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, a, d, 3'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
